// File: rtl/serial_tc_pkg.sv
// Shared definitions for the serial two's-complement negator: counter width
// helper and the per-lane mode encoding.
package serial_tc_pkg;

   localparam logic MODE_PASS = 1'b0;
   localparam logic MODE_NEG  = 1'b1;

   // Width of a counter spanning 0..width-1, never narrower than one bit.
   function automatic int CNT_W(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/serial_tc_lane.sv
// One serial lane: copy bits through the first 1, then invert later bits
// when the word's mode is negate. Overflow detection (most-negative word)
// is built only when SERIAL_TC_OVF_EN is defined; otherwise o_ovf is 0.
module serial_tc_lane
   import serial_tc_pkg::*;
(
   input  logic clk,
   input  logic r_n,
   input  logic i_valid,
   input  logic i_first,
   input  logic i_last,
   input  logic i_in_bit,
   input  logic i_neg_en,
   output logic o_out_bit,
   output logic o_ovf
);

   logic r_mode;
   logic r_seen_one;
   logic r_out_bit;
   logic w_eff_neg;
   logic w_seen_eff;
   logic w_out_next;

   // Bit 0 uses the live mode input; later bits use the mode latched at bit 0.
   assign w_eff_neg  = i_first ? i_neg_en : (r_mode == MODE_NEG);
   assign w_seen_eff = i_first ? 1'b0 : r_seen_one;
   assign w_out_next = i_in_bit ^ (w_eff_neg & w_seen_eff);

   // Mode and seen-one tracking advance only on accepted bits.
   always_ff @(posedge clk) begin
      if (!r_n) begin
         r_mode     <= MODE_PASS;
         r_seen_one <= 1'b0;
         r_out_bit  <= 1'b0;
      end else begin
         r_out_bit <= i_valid & w_out_next;
         if (i_valid) begin
            r_seen_one <= w_seen_eff | i_in_bit;
            if (i_first)
               r_mode <= i_neg_en ? MODE_NEG : MODE_PASS;
         end
      end
   end

   assign o_out_bit = r_out_bit;

`ifdef SERIAL_TC_OVF_EN
   logic r_all_zero;
   logic r_ovf;
   logic w_zero_eff;

   assign w_zero_eff = i_first | r_all_zero;

   // all_zero covers bits 0..WIDTH-2; ovf fires on a negated 100..0 word.
   always_ff @(posedge clk) begin
      if (!r_n) begin
         r_all_zero <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_ovf <= i_valid & i_last & w_eff_neg & w_zero_eff & i_in_bit;
         if (i_valid)
            r_all_zero <= w_zero_eff & ~i_in_bit;
      end
   end

   assign o_ovf = r_ovf;
`else
   logic w_unused_last;
   assign w_unused_last = i_last;
   assign o_ovf         = 1'b0;
`endif

endmodule

// File: rtl/serial_twos_comp_mc.sv
// Multi-lane, word-framed, LSB-first serial two's-complement negator.
// Owns the shared bit counter and framing outputs; per-lane datapath lives
// in serial_tc_lane. Optional overflow flag: SERIAL_TC_OVF_EN.
module serial_twos_comp_mc
   import serial_tc_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 1
) (
   input  logic                clk,
   input  logic                r_n,
   input  logic                in_valid,
   input  logic [CHANNELS-1:0] in_bit,
   input  logic [CHANNELS-1:0] neg_en,
   output logic                out_valid,
   output logic [CHANNELS-1:0] out_bit,
   output logic                out_last,
   output logic [CHANNELS-1:0] ovf
);

   localparam int CW = CNT_W(WIDTH);

   logic [CW-1:0] r_cnt;
   logic          r_out_valid;
   logic          r_out_last;
   logic          w_first;
   logic          w_last;

   assign w_first = (r_cnt == '0);
   assign w_last  = (r_cnt == CW'(WIDTH - 1));

   // Shared bit counter and registered framing; stalls hold the counter.
   always_ff @(posedge clk) begin
      if (!r_n) begin
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         r_out_last  <= in_valid & w_last;
         if (in_valid)
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
   end

   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      serial_tc_lane u_lane (
         .clk       (clk),
         .r_n       (r_n),
         .i_valid   (in_valid),
         .i_first   (w_first),
         .i_last    (w_last),
         .i_in_bit  (in_bit[g]),
         .i_neg_en  (neg_en[g]),
         .o_out_bit (out_bit[g]),
         .o_ovf     (ovf[g])
      );
   end

endmodule

// File: tb/tb_serial_twos_comp_mc.sv
// Bench for serial_twos_comp_mc (WIDTH=8, CHANNELS=2). Overflow expectations
// follow SERIAL_TC_OVF_EN.
module tb_serial_twos_comp_mc;

   logic       clk = 1'b0;
   logic       r_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [1:0] in_bit = 2'b00;
   logic [1:0] neg_en = 2'b00;
   logic       out_valid;
   logic [1:0] out_bit;
   logic       out_last;
   logic [1:0] ovf;

   int n_cmp = 0;
   int n_bad = 0;

   serial_twos_comp_mc #(.WIDTH(8), .CHANNELS(2)) dut (
      .clk       (clk),
      .r_n       (r_n),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .neg_en    (neg_en),
      .out_valid (out_valid),
      .out_bit   (out_bit),
      .out_last  (out_last),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] w0;
      logic [7:0] w1;
      logic [1:0] ovf;
      bit         frame_ok;
      int         gaps;
      int         first_cyc;
      int         last_cyc;
   } rec_t;

   rec_t mon_q[$];

   // Reference: two's-complement negation of the whole word.
   function automatic logic [7:0] model_word(input logic [7:0] v, input logic neg);
      logic [8:0] t;
      t = 9'h100 - {1'b0, v};
      return neg ? t[7:0] : v;
   endfunction

   function automatic logic model_ovf(input logic [7:0] v, input logic neg);
`ifdef SERIAL_TC_OVF_EN
      return neg && (v == 8'h80);
`else
      return 1'b0;
`endif
   endfunction

   // Output monitor: assembles 8-beat words and records framing/timing.
   int         cyc = 0;
   int         m_idx = 0;
   int         m_gaps = 0;
   int         m_first = 0;
   bit         m_ok = 1'b1;
   logic [7:0] m_w0 = '0;
   logic [7:0] m_w1 = '0;
   always @(negedge clk) begin
      cyc++;
      if (!r_n) begin
         m_idx  = 0;
         m_gaps = 0;
         m_ok   = 1'b1;
      end else if (out_valid) begin
         rec_t r;
         if (m_idx == 0) begin
            m_first = cyc;
            m_gaps  = 0;
            m_ok    = 1'b1;
         end
         m_w0[m_idx] = out_bit[0];
         m_w1[m_idx] = out_bit[1];
         if (out_last !== (m_idx == 7)) m_ok = 1'b0;
         if (m_idx != 7 && ovf !== 2'b00) m_ok = 1'b0;
         if (m_idx == 7) begin
            r.w0 = m_w0; r.w1 = m_w1; r.ovf = ovf; r.frame_ok = m_ok;
            r.gaps = m_gaps; r.first_cyc = m_first; r.last_cyc = cyc;
            mon_q.push_back(r);
            m_idx = 0;
         end else begin
            m_idx++;
         end
      end else if (m_idx != 0) begin
         m_gaps++;
      end
   end

   task automatic drive(input logic v, input logic [1:0] b, input logic [1:0] n);
      @(negedge clk);
      in_valid = v;
      in_bit   = b;
      neg_en   = n;
   endtask

   // Sends one word per lane; neg is applied at bit 0, other bits carry
   // noise on neg_en (or the inverse at toggle_at). Optional stall after stall_at.
   task automatic send_word(input logic [7:0] w0, input logic [7:0] w1, input logic [1:0] neg,
                            input int stall_at, input int stall_len, input int toggle_at);
      for (int b = 0; b < 8; b++) begin
         logic [1:0] n;
         if (b == 0) n = neg;
         else if (b == toggle_at) n = ~neg;
         else n = 2'($urandom);
         drive(1'b1, {w1[b], w0[b]}, n);
         if (b == stall_at)
            for (int s = 0; s < stall_len; s++) drive(1'b0, 2'($urandom), 2'($urandom));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'($urandom), 2'($urandom));
   endtask

   task automatic wait_recs(input int n, output bit ok);
      for (int t = 0; t < 400 && mon_q.size() < n; t++) @(negedge clk);
      ok = (mon_q.size() >= n);
   endtask

   task automatic test_reset();
      r_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'($urandom), 2'($urandom));
         n_cmp++;
         if ({out_valid, out_last, out_bit, ovf} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 000000", {out_valid, out_last, out_bit, ovf});
         end
      end
      drive(1'b0, 2'b00, 2'b00);
      r_n = 1'b1;
      idle(2);
      mon_q.delete();
   endtask

   task automatic test_negate_basic();
      rec_t r; bit ok;
      send_word(8'h05, 8'hA7, 2'b01, 99, 0, 99);
      idle(3);
      wait_recs(1, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL basic_timeout: got %0d words required 1", mon_q.size()); return; end
      r = mon_q.pop_front();
      n_cmp++;
      if (r.w0 !== 8'hFB) begin n_bad++; $display("FAIL basic_lane0: got %h required fb", r.w0); end
      n_cmp++;
      if (r.w1 !== 8'hA7) begin n_bad++; $display("FAIL basic_lane1: got %h required a7", r.w1); end
      n_cmp++;
      if (!r.frame_ok || r.ovf !== 2'b00) begin
         n_bad++; $display("FAIL basic_frame: frame_ok %0d ovf %b required 1 00", r.frame_ok, r.ovf);
      end
   endtask

   task automatic test_back_to_back();
      rec_t a, b; bit ok;
      send_word(8'h01, 8'h3C, 2'b01, 99, 0, 99);
      send_word(8'h00, 8'h3C, 2'b11, 99, 0, 99);
      idle(3);
      wait_recs(2, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL b2b_timeout: got %0d words required 2", mon_q.size()); return; end
      a = mon_q.pop_front();
      b = mon_q.pop_front();
      n_cmp++;
      if ({a.w0, a.w1} !== 16'hFF3C) begin n_bad++; $display("FAIL b2b_word_a: got %h required ff3c", {a.w0, a.w1}); end
      n_cmp++;
      if ({b.w0, b.w1} !== 16'h00C4) begin n_bad++; $display("FAIL b2b_word_b: got %h required 00c4", {b.w0, b.w1}); end
      n_cmp++;
      if (b.first_cyc != a.last_cyc + 1 || a.gaps != 0 || b.gaps != 0) begin
         n_bad++; $display("FAIL b2b_bubble: got start %0d after end %0d required adjacent", b.first_cyc, a.last_cyc);
      end
      n_cmp++;
      if (!a.frame_ok || !b.frame_ok) begin n_bad++; $display("FAIL b2b_frame: got %0d%0d required 11", a.frame_ok, b.frame_ok); end
   endtask

   task automatic test_stall();
      rec_t r; bit ok;
      send_word(8'h06, 8'h06, 2'b01, 2, 3, 99);
      idle(3);
      wait_recs(1, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL stall_timeout: got %0d words required 1", mon_q.size()); return; end
      r = mon_q.pop_front();
      n_cmp++;
      if ({r.w0, r.w1} !== 16'hFA06) begin n_bad++; $display("FAIL stall_data: got %h required fa06", {r.w0, r.w1}); end
      n_cmp++;
      if (r.gaps != 3 || r.last_cyc - r.first_cyc != 10 || !r.frame_ok) begin
         n_bad++; $display("FAIL stall_timing: got gaps %0d span %0d frame %0d required 3 10 1", r.gaps, r.last_cyc - r.first_cyc, r.frame_ok);
      end
   endtask

   task automatic test_reset_midword();
      rec_t r; bit ok;
      logic [7:0] v;
      v = 8'h80;
      mon_q.delete();
      for (int b = 0; b < 4; b++) drive(1'b1, {1'b1, v[b]}, 2'b11);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         r_n = 1'b0;
         in_valid = 1'b1;
         in_bit = 2'($urandom);
         if (i > 0) begin
            n_cmp++;
            if ({out_valid, out_last, out_bit, ovf} !== 6'b0) begin
               n_bad++; $display("FAIL midreset_outputs: got %b required 000000", {out_valid, out_last, out_bit, ovf});
            end
         end
      end
      @(negedge clk);
      r_n = 1'b1;
      in_valid = 1'b0;
      send_word(8'h02, 8'h02, 2'b01, 99, 0, 99);
      idle(3);
      wait_recs(1, ok);
      n_cmp++;
      if (!ok || mon_q.size() != 1) begin n_bad++; $display("FAIL midreset_count: got %0d words required 1", mon_q.size()); return; end
      r = mon_q.pop_front();
      n_cmp++;
      if ({r.w0, r.w1} !== 16'hFE02 || !r.frame_ok) begin
         n_bad++; $display("FAIL midreset_word: got %h frame %0d required fe02 1", {r.w0, r.w1}, r.frame_ok);
      end
   endtask

   task automatic test_overflow();
      rec_t a, b; bit ok;
      logic [1:0] exp_ovf;
      send_word(8'h80, 8'h81, 2'b11, 99, 0, 99);
      send_word(8'h80, 8'h00, 2'b10, 99, 0, 99);
      idle(3);
      wait_recs(2, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL ovf_timeout: got %0d words required 2", mon_q.size()); return; end
      a = mon_q.pop_front();
      b = mon_q.pop_front();
      n_cmp++;
      if ({a.w0, a.w1} !== 16'h807F) begin n_bad++; $display("FAIL ovf_word_a: got %h required 807f", {a.w0, a.w1}); end
      exp_ovf = {1'b0, model_ovf(8'h80, 1'b1)};
      n_cmp++;
      if (a.ovf !== exp_ovf || !a.frame_ok) begin
         n_bad++; $display("FAIL ovf_flag_a: got %b frame %0d required %b 1", a.ovf, a.frame_ok, exp_ovf);
      end
      n_cmp++;
      if ({b.w0, b.w1} !== 16'h8000 || b.ovf !== 2'b00) begin
         n_bad++; $display("FAIL ovf_word_b: got %h ovf %b required 8000 00", {b.w0, b.w1}, b.ovf);
      end
   endtask

   task automatic test_mode_sampling();
      rec_t r; bit ok;
      send_word(8'h10, 8'h10, 2'b01, 99, 0, 3);
      idle(3);
      wait_recs(1, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL mode_timeout: got %0d words required 1", mon_q.size()); return; end
      r = mon_q.pop_front();
      n_cmp++;
      if ({r.w0, r.w1} !== 16'hF010) begin n_bad++; $display("FAIL mode_hold: got %h required f010", {r.w0, r.w1}); end
   endtask

   task automatic test_random();
      logic [7:0] v0[30];
      logic [7:0] v1[30];
      logic [1:0] ng[30];
      int         st[30];
      int         sl[30];
      bit         ok;
      for (int i = 0; i < 30; i++) begin
         v0[i] = 8'($urandom);
         v1[i] = 8'($urandom);
         if (i % 7 == 0) v0[i] = 8'h80;
         if (i % 11 == 0) v1[i] = 8'h00;
         ng[i] = 2'($urandom);
         st[i] = $urandom_range(0, 12);
         sl[i] = $urandom_range(1, 3);
         send_word(v0[i], v1[i], ng[i], st[i], sl[i], 99);
      end
      idle(3);
      wait_recs(30, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL rand_timeout: got %0d words required 30", mon_q.size()); return; end
      for (int i = 0; i < 30; i++) begin
         rec_t r;
         logic [7:0] e0, e1;
         logic [1:0] eo;
         int eg;
         r  = mon_q.pop_front();
         e0 = model_word(v0[i], ng[i][0]);
         e1 = model_word(v1[i], ng[i][1]);
         eo = {model_ovf(v1[i], ng[i][1]), model_ovf(v0[i], ng[i][0])};
         eg = (st[i] < 7) ? sl[i] : 0;
         n_cmp++;
         if (r.w0 !== e0 || r.w1 !== e1 || r.ovf !== eo || r.gaps != eg || !r.frame_ok) begin
            n_bad++;
            $display("FAIL rand_word%0d: got %h/%h ovf %b gaps %0d frame %0d required %h/%h ovf %b gaps %0d frame 1",
                     i, r.w0, r.w1, r.ovf, r.gaps, r.frame_ok, e0, e1, eo, eg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_negate_basic();
      test_back_to_back();
      test_stall();
      test_reset_midword();
      test_overflow();
      test_mode_sampling();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
